// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter and its matching receiver.
package uart_pkg;

    // Frame FSM encodings.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } uart_state_e;

    // Line levels on the serial wire.
    localparam logic LineIdle = 1'b1;
    localparam logic StartBit = 1'b0;
    localparam logic StopBit  = 1'b1;

    // Counter width that holds values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period generator: bit_tick marks the last clk cycle of each bit period.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_tick
);

    localparam int unsigned CntW = cnt_width(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Free-running count, restarted on clear so the first period aligns to the accept edge.
    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (clear || (cnt_q == CntMax)) begin
            cnt_d = '0;
        end
    end

    // Cycle counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_tick = (cnt_q == CntMax);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one byte per valid/ready handshake, sent LSB first
// framed by a start bit (0) and a stop bit (1).
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned IdxW = cnt_width(DATA_BITS);
    localparam logic [IdxW-1:0] IdxMax = IdxW'(DATA_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [IdxW-1:0]      bit_idx_q, bit_idx_d;
    logic                 done_q, done_d;
    logic                 accept;
    logic                 bit_tick;

    assign accept = tx_valid && (state_q == StIdle);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk     (clk),
        .reset   (reset),
        .clear   (accept),
        .bit_tick(bit_tick)
    );

    // Frame sequencing, data shifting and done pulse generation.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d   = StStart;
                    shreg_d   = tx_data;
                    bit_idx_d = '0;
                end
            end
            StStart: begin
                if (bit_tick) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_tick) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_idx_q == IdxMax) begin
                        state_d   = StStop;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + IdxW'(1);
                    end
                end
            end
            StStop: begin
                if (bit_tick) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; reset aborts any frame in flight without a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            bit_idx_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
            done_q    <= done_d;
        end
    end

    // Line level decoded purely from registered state, so no input reaches tx combinationally.
    always_comb begin
        tx = LineIdle;
        unique case (state_q)
            StIdle:  tx = LineIdle;
            StStart: tx = StartBit;
            StData:  tx = shreg_q[0];
            StStop:  tx = StopBit;
            default: tx = LineIdle;
        endcase
    end

    assign tx_ready = (state_q == StIdle);
    assign busy     = (state_q != StIdle);
    assign done     = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: scoreboard of expected bytes, checked bit by bit on tx.
module tb_uart_tx;

    localparam int unsigned DB    = 8;
    localparam int unsigned CPB   = 4;
    localparam int unsigned FRAME = (DB + 2) * CPB;

    logic          clk = 1'b0;
    logic          reset;
    logic [DB-1:0] tx_data, tx_data1;
    logic          tx_valid, tx_valid1;
    logic          tx_ready, tx, busy, done;
    logic          tx_ready1, tx1, busy1, done1;

    logic [DB-1:0] exp_q[$];
    logic [DB-1:0] exp_q1[$];

    int n_cmp = 0;
    int n_err = 0;

    uart_tx #(
        .DATA_BITS   (DB),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    uart_tx #(
        .DATA_BITS   (DB),
        .CLKS_PER_BIT(1)
    ) dut1 (
        .clk     (clk),
        .reset   (reset),
        .tx_data (tx_data1),
        .tx_valid(tx_valid1),
        .tx_ready(tx_ready1),
        .tx      (tx1),
        .busy    (busy1),
        .done    (done1)
    );

    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // One-cycle valid pulse; expected byte goes onto the scoreboard.
    task automatic send(input logic [DB-1:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        exp_q.push_back(b);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Wait for a start bit, then check every cycle of the frame and the done cycle.
    task automatic collect_frame(input int max_wait, output int gap);
        logic [DB-1:0]   b;
        logic [DB+1:0]   bits;
        gap = 0;
        @(negedge clk);
        while (tx !== 1'b0 && gap < max_wait) begin
            gap++;
            @(negedge clk);
        end
        if (tx !== 1'b0) begin
            check("start_timeout", tx, 0);
            return;
        end
        check("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() == 0) return;
        b    = exp_q.pop_front();
        bits = {1'b1, b, 1'b0};
        for (int c = 0; c < FRAME; c++) begin
            if (c > 0) @(negedge clk);
            check("tx_bit", tx, bits[c / CPB]);
            check("busy_in_frame", busy, 1);
            check("done_in_frame", done, 0);
        end
        @(negedge clk);
        check("done_pulse", done, 1);
        check("busy_after", busy, 0);
        check("ready_after", tx_ready, 1);
        check("tx_after", tx, 1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_tx"}, tx, 1);
        check({tag, "_ready"}, tx_ready, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int g1, g2, lows, dones;
        logic [DB-1:0] b;
        logic [DB+1:0] bits;

        reset     = 1'b1;
        tx_valid  = 1'b0;
        tx_valid1 = 1'b0;
        tx_data   = '0;
        tx_data1  = '0;

        // Test 1: reset held two cycles.
        @(negedge clk);
        check_idle("rst1");
        check("rst1_tx1", tx1, 1);
        check("rst1_done1", done1, 0);
        @(negedge clk);
        check_idle("rst2");
        reset = 1'b0;
        @(negedge clk);
        check_idle("post_rst");

        // Test 2: single byte 8'hA5.
        fork
            send(8'hA5);
            collect_frame(100, g1);
        join
        check("accept_latency", g1, 1);

        // Test 3: 8'h00 then 8'hFF with valid held; second accepted in the done cycle.
        fork
            begin
                @(negedge clk);
                tx_data  = 8'h00;
                tx_valid = 1'b1;
                exp_q.push_back(8'h00);
                @(negedge clk);
                tx_data = 8'hFF;
                exp_q.push_back(8'hFF);
                for (int i = 0; i < 100; i++) begin
                    @(negedge clk);
                    if (tx_ready) break;
                end
                @(negedge clk);
                tx_valid = 1'b0;
            end
            begin
                collect_frame(100, g1);
                collect_frame(3, g2);
            end
        join
        check("b2b_gap", g2, 0);

        // Test 4: data change and valid pulse during bit 2 are ignored.
        fork
            begin
                send(8'h5A);
                repeat (12) @(negedge clk);
                tx_data  = 8'hFF;
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
            end
            collect_frame(100, g1);
        join
        lows  = 0;
        dones = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
            if (done !== 1'b0) dones++;
        end
        check("no_queued_frame", lows, 0);
        check("no_extra_done", dones, 0);

        // Test 5: reset for one cycle during data bit 3, then a clean frame.
        send(8'hC3);
        repeat (17) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        check_idle("mid_rst");
        dones = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || tx !== 1'b1) dones++;
        end
        check("aborted_quiet", dones, 0);
        fork
            send(8'h3C);
            collect_frame(100, g1);
        join
        check("post_rst_latency", g1, 1);

        // Test 6: CLKS_PER_BIT=1 instance sends 8'h81.
        @(negedge clk);
        tx_data1  = 8'h81;
        tx_valid1 = 1'b1;
        exp_q1.push_back(8'h81);
        @(negedge clk);
        tx_valid1 = 1'b0;
        b    = exp_q1.pop_front();
        bits = {1'b1, b, 1'b0};
        for (int c = 0; c < DB + 2; c++) begin
            if (c > 0) @(negedge clk);
            check("fast_tx_bit", tx1, bits[c]);
            check("fast_done_low", done1, 0);
        end
        @(negedge clk);
        check("fast_done", done1, 1);
        check("fast_ready", tx_ready1, 1);
        @(negedge clk);
        check("fast_done_once", done1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
